// File: rtl/csr_timer_pkg.sv
// csr_timer_pkg: shared constants for the CSR timer bank.
// TCFG field positions, per-channel address offsets, default CSR addresses
// and the masked-write / channel-address helpers.
package csr_timer_pkg;

    // TCFG field positions
    localparam int unsigned TCFG_EN          = 0;
    localparam int unsigned TCFG_PERIODIC    = 1;
    localparam int unsigned TCFG_INITVAL_LSB = 2;

    // Per-channel register offsets from that channel's TCFG address
    localparam logic [13:0] OFF_TCFG  = 14'd0;
    localparam logic [13:0] OFF_TVAL  = 14'd1;
    localparam logic [13:0] OFF_TICLR = 14'd3;
    localparam logic [13:0] STRIDE    = 14'd4;

    // Default CSR addresses
    localparam logic [13:0] DEF_TCFG_BASE = 14'h041;
    localparam logic [13:0] DEF_CNTC_ADDR = 14'h043;

    // Bits selected by wmask take wdata; the rest keep their old value.
    function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                                 input logic [31:0] wdata,
                                                 input logic [31:0] wmask);
        return (wdata & wmask) | (old_v & ~wmask);
    endfunction

    // CSR address of register 'off' in channel 'idx'.
    function automatic logic [13:0] chan_addr(input logic [13:0] base,
                                              input int unsigned idx,
                                              input logic [13:0] off);
        return base + 14'(idx) * STRIDE + off;
    endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// csr_timer_chan: one down-counting timer channel (TCFG, TVAL, pending).
// TCFG bit 0 is the live enable: a one-shot expiry clears it, so TCFG
// readback always shows whether the channel is still counting.
module csr_timer_chan
    import csr_timer_pkg::*;
#(
    parameter int unsigned TVAL_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick_i,
    input  logic              tcfg_we_i,
    input  logic              ticlr_we_i,
    input  logic [TVAL_W-1:0] wmask_i,
    input  logic [TVAL_W-1:0] wdata_i,
    output logic [TVAL_W-1:0] tcfg_o,
    output logic [TVAL_W-1:0] tval_o,
    output logic              pending_o
);

    logic [TVAL_W-1:0] tcfg_q, tcfg_d;
    logic [TVAL_W-1:0] tval_q, tval_d;
    logic              pend_q, pend_d;
    logic [TVAL_W-1:0] tcfg_new;
    logic              expire;

    // Reload value: InitVal field with the two low bits forced to zero.
    function automatic logic [TVAL_W-1:0] load_val(input logic [TVAL_W-1:0] cfg);
        logic [TVAL_W-1:0] v;
        v = cfg;
        v[TCFG_INITVAL_LSB-1:0] = '0;
        return v;
    endfunction

    assign tcfg_new = (wdata_i & wmask_i) | (tcfg_q & ~wmask_i);

    // Next-state: a TCFG write overrides any count or expiry in the same
    // cycle; an expiry beats a simultaneous TICLR so no interrupt is lost.
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        pend_d = pend_q;
        expire = 1'b0;
        if (tcfg_we_i) begin
            tcfg_d = tcfg_new;
            tval_d = load_val(tcfg_new);
        end else if (tick_i && tcfg_q[TCFG_EN]) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TVAL_W'(1);
            end else begin
                expire = 1'b1;
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = load_val(tcfg_q);
                end else begin
                    tval_d          = '1;
                    tcfg_d[TCFG_EN] = 1'b0;
                end
            end
        end
        if (expire) begin
            pend_d = 1'b1;
        end else if (ticlr_we_i) begin
            pend_d = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tcfg_q <= '0;
            tval_q <= '0;
            pend_q <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            pend_q <= pend_d;
        end
    end

    assign tcfg_o    = tcfg_q;
    assign tval_o    = tval_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS timer channels, 64-bit stable counter and
// CNTC offset, decoded from the CSR write/read bus.
// Optional feature macro: CSR_TIMER_PRESCALE_EN (shared tick prescaler).
module csr_timer_bank
    import csr_timer_pkg::*;
#(
    parameter int unsigned NUM_TIMERS = 1,
    parameter int unsigned TVAL_W     = 32,
    parameter logic [13:0] TCFG_BASE  = DEF_TCFG_BASE,
    parameter logic [13:0] CNTC_ADDR  = DEF_CNTC_ADDR,
    parameter logic [31:0] COUNTER_ID = 32'h0,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  csr_we,
    input  logic [13:0]           csr_waddr,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wdata,
    input  logic [13:0]           csr_raddr,
    output logic [31:0]           csr_rdata,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic [63:0]           counter,
    output logic [31:0]           counterID
);

    logic [63:0] stable_q, stable_d;
    logic [31:0] cntc_q, cntc_d;
    logic        tick;
    logic [31:0] tcfg_rd [NUM_TIMERS];
    logic [31:0] tval_rd [NUM_TIMERS];

`ifdef CSR_TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PRESC_LAST = (PRESCALE > 1) ? PRESCALE - 1 : 0;

    logic [PW-1:0] presc_q, presc_d;

    assign tick = (presc_q == PW'(PRESC_LAST));

    // Prescaler wraps after PRESCALE cycles; never restarted by TCFG writes
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // Without the prescaler every cycle is a tick and PRESCALE has no effect.
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    // Stable counter free-runs; CNTC takes masked writes
    always_comb begin
        stable_d = stable_q + 64'd1;
        cntc_d   = cntc_q;
        if (csr_we && (csr_waddr == CNTC_ADDR)) begin
            cntc_d = masked_write(cntc_q, csr_wdata, csr_wmask);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stable_q <= '0;
            cntc_q   <= '0;
        end else begin
            stable_q <= stable_d;
            cntc_q   <= cntc_d;
        end
    end

    assign counter   = stable_q + {{32{cntc_q[31]}}, cntc_q};
    assign counterID = COUNTER_ID;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        logic [TVAL_W-1:0] tcfg;
        logic [TVAL_W-1:0] tval;
        logic              tcfg_we;
        logic              ticlr_we;

        assign tcfg_we  = csr_we && (csr_waddr == chan_addr(TCFG_BASE, g, OFF_TCFG));
        assign ticlr_we = csr_we && (csr_waddr == chan_addr(TCFG_BASE, g, OFF_TICLR))
                          && csr_wdata[0];

        csr_timer_chan #(
            .TVAL_W(TVAL_W)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .tick_i    (tick),
            .tcfg_we_i (tcfg_we),
            .ticlr_we_i(ticlr_we),
            .wmask_i   (csr_wmask[TVAL_W-1:0]),
            .wdata_i   (csr_wdata[TVAL_W-1:0]),
            .tcfg_o    (tcfg),
            .tval_o    (tval),
            .pending_o (timer_int[g])
        );

        assign tcfg_rd[g] = 32'(tcfg);
        assign tval_rd[g] = 32'(tval);
    end

    // Read mux: CNTC and per-channel TCFG/TVAL; TICLR and unmapped read 0
    always_comb begin
        csr_rdata = '0;
        if (csr_raddr == CNTC_ADDR) begin
            csr_rdata = cntc_q;
        end
        for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (csr_raddr == chan_addr(TCFG_BASE, i, OFF_TCFG)) begin
                csr_rdata = tcfg_rd[i];
            end else if (csr_raddr == chan_addr(TCFG_BASE, i, OFF_TVAL)) begin
                csr_rdata = tval_rd[i];
            end
        end
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb_csr_timer_bank: directed scoreboard bench for csr_timer_bank (2 channels).
module tb_csr_timer_bank;

  localparam logic [13:0] A_TCFG0  = 14'h041;
  localparam logic [13:0] A_TVAL0  = 14'h042;
  localparam logic [13:0] A_CNTC   = 14'h043;
  localparam logic [13:0] A_TICLR0 = 14'h044;
  localparam logic [13:0] A_TCFG1  = 14'h045;
  localparam logic [13:0] A_TVAL1  = 14'h046;
  localparam logic [13:0] A_TICLR1 = 14'h048;
  localparam logic [13:0] A_TCFG2  = 14'h049;
  localparam logic [13:0] A_TVAL2  = 14'h04A;

  logic        clk = 1'b0;
  logic        rstn;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [1:0]  timer_int;
  logic [63:0] counter;
  logic [31:0] counterID;

  always #5 clk = ~clk;

  csr_timer_bank #(
    .NUM_TIMERS(2),
    .PRESCALE  (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .csr_we   (csr_we),
    .csr_waddr(csr_waddr),
    .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata),
    .timer_int(timer_int),
    .counter  (counter),
    .counterID(counterID)
  );

  typedef enum int {K_RD, K_INT, K_CNT, K_DCNT, K_ID} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] prev_cnt = '0;

  always @(negedge clk) begin
    chk_t        e;
    logic [63:0] act;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = {32'b0, csr_rdata};
        K_INT:   act = {62'b0, timer_int};
        K_CNT:   act = counter;
        K_ID:    act = {32'b0, counterID};
        default: act = counter - prev_cnt;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end
    end
    prev_cnt = counter;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input kind_e k, input logic [63:0] exp, input string nm);
    chk_t e;
    e.kind = k;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic chk_rd(input logic [13:0] a, input logic [31:0] exp, input string nm);
    csr_raddr = a;
    push(K_RD, {32'b0, exp}, nm);
  endtask

  task automatic chk_int(input logic [1:0] exp, input string nm);
    push(K_INT, {62'b0, exp}, nm);
  endtask

  task automatic chk_dcnt(input logic [63:0] exp, input string nm);
    push(K_DCNT, exp, nm);
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d,
                           input logic [31:0] m = 32'hFFFF_FFFF);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    csr_wmask = m;
    step();
    csr_we    = 1'b0;
    csr_wmask = '0;
    csr_wdata = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wmask = '0;
    csr_wdata = '0;
    csr_raddr = '0;
    step(2);

    push(K_CNT, 64'd0, "cnt_reset");
    push(K_ID, 64'd0, "counter_id");
    chk_int(2'b00, "int_reset");
    chk_rd(A_TCFG0, 32'h0, "tcfg0_reset");
    rstn = 1'b1;
    step();
    chk_rd(A_TVAL0, 32'h0, "tval0_reset");
    chk_dcnt(64'd1, "cnt_step_a");
    step();
    chk_rd(A_CNTC, 32'h0, "cntc_reset");
    chk_dcnt(64'd1, "cnt_step_b");
    step();
    chk_rd(A_TICLR0, 32'h0, "ticlr0_reads0");
    chk_int(2'b00, "int_idle");
    step();

`ifndef CSR_TIMER_PRESCALE_EN
    csr_write(A_TCFG0, 32'h0000_0009);
    chk_rd(A_TVAL0, 32'd8, "oneshot_load");
    chk_int(2'b00, "oneshot_int_low");
    step();
    chk_rd(A_TCFG0, 32'h9, "tcfg0_readback");
    step(7);
    chk_rd(A_TVAL0, 32'd0, "oneshot_zero");
    chk_int(2'b00, "oneshot_before_fire");
    step();
    chk_int(2'b01, "oneshot_fire");
    chk_rd(A_TVAL0, 32'hFFFF_FFFF, "oneshot_allones");
    step();
    chk_rd(A_TCFG0, 32'h8, "oneshot_en_cleared");
    step(3);
    chk_rd(A_TVAL0, 32'hFFFF_FFFF, "oneshot_hold");
    chk_int(2'b01, "oneshot_int_held");
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b00, "ticlr_clear");

    csr_write(A_TCFG0, 32'h0000_0007);
    chk_rd(A_TVAL0, 32'd4, "periodic_load");
    step(4);
    chk_rd(A_TVAL0, 32'd0, "periodic_zero");
    chk_int(2'b00, "periodic_pre");
    step();
    chk_int(2'b01, "periodic_fire1");
    chk_rd(A_TVAL0, 32'd4, "periodic_reload");
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b00, "periodic_clr1");
    chk_rd(A_TVAL0, 32'd3, "periodic_count");
    step(4);
    chk_int(2'b01, "periodic_fire2");
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b00, "periodic_clr2");
    step(3);
    chk_rd(A_TVAL0, 32'd0, "periodic_zero3");
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b01, "set_beats_clear");
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b00, "periodic_clr3");
    step(3);
    chk_rd(A_TVAL0, 32'd0, "periodic_zero4");
    csr_write(A_TCFG0, 32'h0000_000D);
    chk_int(2'b00, "tcfg_beats_expiry");
    chk_rd(A_TVAL0, 32'd12, "tcfg_reload_on_expiry");
    csr_write(A_TCFG0, 32'h0);
    step();

    csr_write(A_TCFG1, 32'h0000_0005);
    csr_write(A_TCFG0, 32'h0000_000D);
    chk_rd(A_TVAL0, 32'd12, "ch0_load");
    step();
    chk_rd(A_TVAL1, 32'd2, "ch1_count");
    step(3);
    chk_int(2'b10, "ch1_fire");
    chk_rd(A_TVAL2, 32'h0, "oor_tval2");
    step();
    chk_rd(A_TCFG2, 32'h0, "oor_tcfg2");
    step(7);
    chk_int(2'b10, "ch0_not_yet");
    chk_rd(A_TVAL0, 32'd0, "ch0_zero");
    step();
    chk_int(2'b11, "ch0_fire");
    chk_rd(A_TCFG1, 32'h4, "ch1_en_cleared");
    step();
    csr_write(A_TICLR0, 32'h1);
    chk_int(2'b10, "ticlr0_only");
    csr_write(A_TICLR1, 32'h1);
    chk_int(2'b00, "ticlr1_clear");

    csr_write(A_TCFG1, 32'hFFFF_FFF1, 32'h0000_0001);
    chk_rd(A_TCFG1, 32'h5, "tcfg_masked");
    csr_write(A_TVAL1, 32'h0000_0123);
    chk_rd(A_TVAL1, 32'd3, "tval_readonly");
    csr_write(A_TCFG1, 32'h0);
`else
    csr_write(A_TCFG0, 32'h0000_000D);
    chk_rd(A_TVAL0, 32'd12, "presc_load");
    step(8);
    chk_rd(A_TVAL0, 32'd10, "presc_8cyc");
    step(4);
    chk_rd(A_TVAL0, 32'd9, "presc_4cyc");
    csr_write(A_TCFG0, 32'h0);
`endif

    chk_dcnt(64'd1, "cnt_step_c");
    csr_write(A_CNTC, 32'hFFFF_FFFF);
    chk_dcnt(64'd0, "cntc_neg1_delta");
    chk_rd(A_CNTC, 32'hFFFF_FFFF, "cntc_readback");
    step();
    chk_dcnt(64'd1, "cnt_step_d");
    csr_write(A_CNTC, 32'h0, 32'hFFFF_0000);
    chk_rd(A_CNTC, 32'h0000_FFFF, "cntc_masked");
    chk_dcnt(64'h1_0001, "cntc_masked_delta");
    step();

    csr_write(A_TCFG0, 32'h0000_000F);
    step(2);
    rstn = 1'b0;
    step();
    chk_rd(A_TVAL0, 32'h0, "rst_mid_tval");
    push(K_CNT, 64'd0, "rst_mid_cnt");
    rstn = 1'b1;
    step();
    chk_rd(A_TCFG0, 32'h0, "rst_mid_tcfg");
    step(20);
    chk_int(2'b00, "rst_mid_idle");
    chk_rd(A_TVAL0, 32'h0, "rst_mid_tval_idle");
    step();

    if (timer_int !== 2'b00) begin
      n_bad++;
      $display("FAIL final_int: got 0x%0h, expected 0x0", timer_int);
    end
    if (counterID !== 32'h0) begin
      n_bad++;
      $display("FAIL final_counter_id: got 0x%0h, expected 0x0", counterID);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d checks left unchecked", sb.size());
    end
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL check_count: only %0d comparisons made", n_cmp);
    end
    if (n_bad != 0) begin
      $display("FAIL overall: %0d mismatches", n_bad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_timer_bank.md
# csr_timer_bank

Parametrised timer/counter block for the CPU's CSR file, holding NUM_TIMERS independent down-counting timers (TCFG/TVAL/TICLR per channel), the 64-bit stable counter, and the CNTC offset register. It sits beside the main CSR register file. It decodes the same CSR write/read bus. It drives per-channel timer interrupt lines into ESTAT.IS and supplies counter/counterID to the RDCNT path. Channel 0 at default parameters is the architectural single timer.

## Interface
Parameters:
- NUM_TIMERS, 1, number of timer channels (1..8)
- TVAL_W, 32, timer width; InitVal field is TCFG[TVAL_W-1:2]
- TCFG_BASE, 14'h041, address of channel 0 TCFG; channel i uses TCFG_BASE+4i (TCFG), +1 (TVAL), +3 (TICLR)
- CNTC_ADDR, 14'h043, CNTC address
- COUNTER_ID, 32'h0, constant driven on counterID
- PRESCALE, 1, timer tick divisor (≥1; used only with CSR_TIMER_PRESCALE_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- csr_we  in  1  CSR write strobe
- csr_waddr  in  14  write address
- csr_wmask  in  32  per-bit write mask
- csr_wdata  in  32  write data
- csr_raddr  in  14  read address
- csr_rdata  out  32  combinational read data
- timer_int  out  NUM_TIMERS  per-channel pending interrupt (registered)
- counter  out  64  stable counter plus sign-extended CNTC
- counterID  out  32  COUNTER_ID

## Operation
- Masked write rule: reg <= wdata&wmask | reg&~wmask. It applies to TCFG and CNTC.
- TCFG bits: [0] En, [1] Periodic, [TVAL_W-1:2] InitVal. Bits above TVAL_W read 0.
- TCFG write: new TCFG is latched. TVAL <= {new InitVal,2'b00}. En follows the new En bit. Any in-flight count is discarded.
- TVAL is read-only. Writes to it are ignored.
- Per tick with En=1:
  - TVAL≠0: TVAL decrements by 1.
  - TVAL==0 (expiry): pending is set.
    - Periodic=1: TVAL <= {InitVal,00} and En stays 1.
    - Periodic=0: TVAL <= all-ones and En <= 0.
- InitVal=0 with Periodic=1 expires on every tick.
- TICLR write with wdata[0]=1 clears pending. TICLR reads 0.
- Simultaneous expiry and TICLR clear on one channel: set wins, so no interrupt is lost.
- TCFG write in the same cycle as expiry: the TCFG write wins and pending is not set.
- Stable counter: a 64-bit free-running register, +1 every clk, wraps 2^64-1→0. counter = stable + {{32{CNTC[31]}},CNTC}, truncated to 64 bits.
- Read mux: TCFG/TVAL per channel, CNTC, TICLR=0. Unmapped or out-of-range channel addresses return 0.

## Timing
- Reset values: TCFG=0, TVAL=0, En=0, pending=0, CNTC=0, stable=0, timer_int=0, prescaler=0.
- Write to readback: 1 cycle (next-cycle csr_rdata).
- TCFG write at cycle n with InitVal=k (k≥1), PRESCALE=1:
  - TVAL=4k at n+1.
  - TVAL reaches 0 at n+1+4k.
  - pending and timer_int rise at n+2+4k.
- timer_int is the pending flop directly, with no extra stage.
- counter changes every cycle. A CNTC write is reflected 1 cycle later.
- Reset mid-count returns all channels to disabled and idle.

## Configuration
- CSR_TIMER_PRESCALE_EN defined:
  - A shared prescaler counts 0..PRESCALE-1, and tick=1 when it equals PRESCALE-1.
  - The prescaler free-runs from reset and is not restarted by TCFG writes.
  - Timers advance only on tick. The stable counter is unaffected.
- CSR_TIMER_PRESCALE_EN undefined: tick=1 every cycle, PRESCALE is ignored, and no prescaler logic is built.

## Structure
- Package csr_timer_pkg holds:
  - TCFG bit positions (EN, PERIODIC, INITVAL_LSB)
  - channel address offsets (OFF_TCFG=0, OFF_TVAL=1, OFF_TICLR=3, STRIDE=4)
  - default CSR addresses
- Sub-module csr_timer_chan contains one channel: TCFG, TVAL, En, pending, and the expiry logic. It is generated NUM_TIMERS times.
- The top level holds address decode, the read mux, the stable counter, CNTC and the prescaler.

## Test plan
- Reset, then read TCFG0/TVAL0/CNTC/TICLR0 -> all 0, timer_int=0, counter increments by 1 per cycle.
- Write TCFG0=0x0000_0009 (En, one-shot, InitVal=2) -> TVAL0=8 next cycle. timer_int[0] rises 9 cycles after TVAL=8. TVAL0 then reads 0xFFFF_FFFF and En=0.
- Write TCFG0=0x0000_0007 (periodic, InitVal=1) -> expiry every 5 cycles. Clear TICLR0 each time, so timer_int pulses repeatedly.
- Arrange TICLR0 (wdata=1) in the same cycle as expiry -> timer_int[0] stays 1.
- NUM_TIMERS=2, channel 1 at 0x045 with InitVal=1 and channel 0 with InitVal=3 -> channels expire independently and read 0x04A returns 0.
- Write CNTC=0xFFFF_FFFF -> counter equals stable−1 from next cycle. With CSR_TIMER_PRESCALE_EN and PRESCALE=4, TVAL decrements once per 4 cycles.
